// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - counts cycles spent waiting for read data; flags expiry
module fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  // saturates at the limit so expired stays asserted until cleared
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with PC redirect and timeout fault
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        fault
);

  fetch_state_t state_q, state_d;

  logic        fetch_start;
  logic        done;
  logic        timed_out;
  logic        expired;
  logic        timer_clear;
  logic        timer_enable;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        write_ok;
  logic        bad_write;

  // once faulted, redirects are ignored entirely
  assign write_ok  = pc_write && !fault && (pc_next[1:0] == 2'b00);
  assign bad_write = pc_write && !fault && (pc_next[1:0] != 2'b00);

  assign timer_clear  = (state_q != S_WAIT);
  assign timer_enable = (state_q == S_WAIT) && !mem_rvalid;

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    fetch_start = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_req && !fault && !bad_write) begin
          fetch_start = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (expired) begin
          timed_out = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      instr       <= NOP_INSTR;
      old_pc      <= RESET_PC;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
    end else begin
      instr_valid <= done;
      if (bad_write || timed_out) fault <= 1'b1;
      // a redirect in the same IDLE cycle as the request is fetched directly
      if (fetch_start) mem_addr <= write_ok ? pc_next : pc;

      if (state_q == S_IDLE) begin
        if (write_ok) pc <= pc_next;
      end else if (done) begin
        instr      <= mem_rdata;
        old_pc     <= mem_addr;
        pend_valid <= 1'b0;
        if (!fault) begin
          if (write_ok)        pc <= pc_next;
          else if (pend_valid) pc <= pend_pc;
          else                 pc <= pc + 32'd4;
        end
      end else if (timed_out) begin
        pend_valid <= 1'b0;
      end else if (write_ok) begin
        pend_valid <= 1'b1;
        pend_pc    <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] old_pc;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fault;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .pc_write   (pc_write),
    .pc_next    (pc_next),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .old_pc     (old_pc),
    .pc         (pc),
    .instr_valid(instr_valid),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every instr_valid pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr_valid: got instr %h old_pc %h expected no completion", instr, old_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_old_pc", old_pc, e.old_pc);
        check("sb_pc", pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    fetch_req  = 1'b0;
    pc_write   = 1'b0;
    pc_next    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
  endtask

  // gd/rd: extra cycles before gnt/rvalid; byp: redirect with request; wwr: redirect in WAIT
  task automatic fetch(input int gd, input int rd, input logic [31:0] data,
                       input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                       input bit byp, input bit wwr, input logic [31:0] tgt);
    exp_t e;
    e.instr  = data;
    e.old_pc = exp_addr;
    e.pc     = exp_pc;
    sb_q.push_back(e);
    fetch_req = 1'b1;
    pc_write  = byp;
    pc_next   = tgt;
    tick();
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      check("req_mem_req", {31'b0, mem_req}, 32'd1);
      check("req_addr", mem_addr, exp_addr);
      if (i == gd) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      check("wait_mem_req", {31'b0, mem_req}, 32'd0);
      check("wait_addr", mem_addr, exp_addr);
      check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
      if (i == 0 && wwr) begin
        pc_write = 1'b1;
        pc_next  = tgt;
      end else begin
        pc_write = 1'b0;
      end
      if (i == rd) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      tick();
    end
    pc_write   = 1'b0;
    mem_rvalid = 1'b0;
    check("done_valid", {31'b0, instr_valid}, 32'd1);
    tick();
    check("pulse_single", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    do_reset();

    // immediate gnt/rvalid: instr_valid after the third edge
    fetch(0, 0, 32'h0050_0093, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0);
    // delayed handshake
    fetch(2, 3, 32'h00a0_0113, 32'h4, 32'h8, 1'b0, 1'b0, 32'h0);
    // IDLE redirect bypasses into the same fetch
    fetch(0, 0, 32'h0010_0193, 32'h100, 32'h104, 1'b1, 1'b0, 32'h100);
    // redirect while waiting replaces pc+4
    fetch(1, 2, 32'h0020_0213, 32'h104, 32'h200, 1'b0, 1'b1, 32'h200);

    // misaligned redirect faults and blocks fetches
    pc_write = 1'b1;
    pc_next  = 32'h102;
    tick();
    pc_write = 1'b0;
    check("mis_fault", {31'b0, fault}, 32'd1);
    check("mis_pc", pc, 32'h200);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_blocked_req", {31'b0, mem_req}, 32'd0);
    end
    fetch_req = 1'b0;
    check("mis_pc_hold", pc, 32'h200);
    check("mis_instr_hold", instr, 32'h0020_0213);

    // read data never arrives: fault after 16 WAIT cycles
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (15) tick();
    check("to_not_yet", {31'b0, fault}, 32'd0);
    tick();
    check("to_fault", {31'b0, fault}, 32'd1);
    check("to_mem_req", {31'b0, mem_req}, 32'd0);
    check("to_instr", instr, 32'h0000_0013);
    check("to_old_pc", old_pc, 32'h0);
    check("to_pc", pc, 32'h0);

    // reset mid-WAIT; the late rvalid must be ignored
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    tick();
    mem_rvalid = 1'b0;
    check("late_rv_instr", instr, 32'h0000_0013);
    check("late_rv_valid", {31'b0, instr_valid}, 32'd0);
    check("late_rv_pc", pc, 32'h0);
    tick();

    // top-of-memory fetch wraps pc to zero
    fetch(0, 1, 32'h0000_006f, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC);

    tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
